alu_issue_unit: RTL and testbench

- Command front-end that drives the team's combinational ALU. It accepts operand/op commands over a valid/ready interface and buffers them in a small FIFO.
- Each command is registered onto the ALU inputs for one cycle. The ALU result and flags are captured and returned in order over a valid/ready response interface, carrying the command's tag.
- Maintains an accumulator (last result) usable as operand A with zero-bubble forwarding, plus sticky carry/overflow flags.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_issue_unit.sv | 143 ++++++++++++++
 tb/tb_alu_issue_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command front-end: opcode width and the
// bit positions used in the response flag and sticky flag vectors.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int STICKY_C = 1;
    localparam int STICKY_V = 0;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrapping pointers and an
// occupancy counter one bit wider than the pointers.
module alu_cmd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Command front-end for the combinational ALU: buffers commands, registers
// them onto the ALU inputs and returns captured results in order with tags.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    input  logic [3:0]          cmd_op,
    input  logic                cmd_acc,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [3:0]          alu_op,
    input  logic [WIDTH-1:0]    alu_y,
    input  logic                alu_carry,
    input  logic                alu_overflow,
    input  logic                alu_zero,
    input  logic                alu_negative,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_y,
    output logic [3:0]          rsp_flags,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [WIDTH-1:0]    acc_value,
    output logic [1:0]          sticky_flags,
    input  logic                flags_clr
);

    localparam int ENTRY_W = TAG_W + 1 + ALU_OP_W + 2 * WIDTH;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] fifo_in;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count_unused;

    logic [WIDTH-1:0]    head_a;
    logic [WIDTH-1:0]    head_b;
    logic [ALU_OP_W-1:0] head_op;
    logic                head_acc;
    logic [TAG_W-1:0]    head_tag;

    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic               advance;
    logic               load;
    logic [3:0]         alu_flags;
    logic [1:0]         sticky_cap;

    assign fifo_in = {cmd_tag, cmd_acc, cmd_op, cmd_b, cmd_a};

    assign head_a   = fifo_head[WIDTH-1:0];
    assign head_b   = fifo_head[2*WIDTH-1:WIDTH];
    assign head_op  = fifo_head[2*WIDTH +: ALU_OP_W];
    assign head_acc = fifo_head[2*WIDTH + ALU_OP_W];
    assign head_tag = fifo_head[ENTRY_W-1 -: TAG_W];

    assign cmd_ready = !fifo_full;
    assign advance   = vld_p1 && (!rsp_valid || rsp_ready);
    assign load      = !fifo_empty && (!vld_p1 || advance);

    alu_cmd_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (load),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    always_comb begin
        alu_flags              = '0;
        alu_flags[FLAG_C]      = alu_carry;
        alu_flags[FLAG_V]      = alu_overflow;
        alu_flags[FLAG_Z]      = alu_zero;
        alu_flags[FLAG_N]      = alu_negative;
        sticky_cap             = '0;
        sticky_cap[STICKY_C]   = alu_carry;
        sticky_cap[STICKY_V]   = alu_overflow;
    end

    // Issue stage: FIFO head -> ALU operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            tag_p1 <= head_tag;
            alu_b  <= head_b;
            alu_op <= head_op;
            // Forward the result being captured now so accumulate chains never stall.
            if (head_acc) alu_a <= advance ? alu_y : acc_value;
            else          alu_a <= head_a;
        end else if (advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // Response stage: ALU result capture, accumulator and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_y        <= '0;
            rsp_flags    <= '0;
            rsp_tag      <= '0;
            acc_value    <= '0;
            sticky_flags <= '0;
        end else begin
            if (advance) begin
                rsp_valid <= 1'b1;
                rsp_y     <= alu_y;
                rsp_flags <= alu_flags;
                rsp_tag   <= tag_p1;
                acc_value <= alu_y;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Clear applies first so a same-cycle capture still lands.
            sticky_flags <= (flags_clr ? 2'b00 : sticky_flags)
                          | (advance ? sticky_cap : 2'b00);
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: adder ALU stub, in-order response model with
// accumulator and sticky-flag tracking, directed cases and random traffic.
module tb_alu_issue_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, cmd_valid, cmd_ready, cmd_acc;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [3:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [3:0]       alu_op;
    logic             alu_carry, alu_overflow, alu_zero, alu_negative;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_y, acc_value;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       sticky_flags;
    logic             flags_clr;

    // Adder stub standing in for the team ALU.
    logic [WIDTH:0] stub_sum;
    assign stub_sum     = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_y        = stub_sum[WIDTH-1:0];
    assign alu_carry    = stub_sum[WIDTH];
    assign alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_y[WIDTH-1] != alu_a[WIDTH-1]);
    assign alu_zero     = (alu_y == '0);
    assign alu_negative = alu_y[WIDTH-1];

    alu_issue_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_acc(cmd_acc), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .acc_value(acc_value), .sticky_flags(sticky_flags), .flags_clr(flags_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [WIDTH-1:0] y;
        logic [3:0]       f;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             q[$];
    exp_t             e;
    logic [WIDTH-1:0] m_acc, last_y, a_eff;
    logic [1:0]       m_sticky, cap;
    bit               head_seen, prev_clr, live;
    longint unsigned  ua, ub, us;
    longint           sa, sb, ss;

    always @(negedge clk) begin
        if (live) begin
            cap = 2'b00;
            if (rsp_valid && q.size() > 0 && !head_seen) cap = {q[0].f[3], q[0].f[2]};
            m_sticky = (prev_clr ? 2'b00 : m_sticky) | cap;
            if (q.size() < DEPTH) check("cmd_ready_open", cmd_ready, 1);
            if (q.size() == DEPTH + 2) check("cmd_ready_full", cmd_ready, 0);
            if (rsp_valid) begin
                if (q.size() == 0) check("stale_rsp", rsp_valid, 0);
                else begin
                    check("rsp_y", rsp_y, q[0].y);
                    check("rsp_flags", rsp_flags, q[0].f);
                    check("rsp_tag", rsp_tag, q[0].tag);
                    check("acc_busy", acc_value, q[0].y);
                end
                head_seen = 1;
            end else begin
                check("acc_idle", acc_value, last_y);
            end
            check("sticky", sticky_flags, m_sticky);
        end
        if (rst) begin
            q.delete();
            m_acc = '0; last_y = '0; m_sticky = 2'b00;
            head_seen = 0; prev_clr = 0; live = 1;
        end else if (live) begin
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                last_y = q[0].y;
                void'(q.pop_front());
                head_seen = 0;
            end
            if (cmd_valid && cmd_ready) begin
                a_eff = cmd_acc ? m_acc : cmd_a;
                ua = a_eff; ub = cmd_b; us = ua + ub;
                sa = $signed(a_eff); sb = $signed(cmd_b); ss = sa + sb;
                e.y   = us[WIDTH-1:0];
                e.f   = {us[WIDTH], (ss > SMAX) || (ss < SMIN), us[WIDTH-1:0] == 0, us[WIDTH-1]};
                e.tag = cmd_tag;
                m_acc = e.y;
                q.push_back(e);
            end
            prev_clr = flags_clr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] op, input logic acc, input logic [TAG_W-1:0] tag);
        cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_acc = acc; cmd_tag = tag;
    endtask

    int nacc, seen;
    logic [TAG_W-1:0] got[$];
    logic [TAG_W-1:0] last_tag;

    initial begin
        rst = 1; cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_acc = 0;
        cmd_tag = '0; rsp_ready = 1; flags_clr = 0;
        repeat (2) tick();
        rst = 0;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_acc", acc_value, 0);
        check("reset_sticky", sticky_flags, 0);
        check("reset_alu_a", alu_a, 0);

        // single wrapping add, latency and flags
        send(32'hFFFF_FFFF, 32'd1, 4'd5, 0, 4'd2);
        tick();
        cmd_valid = 0;
        tick();
        check("lat_alu_a", alu_a, 32'hFFFF_FFFF);
        check("lat_alu_b", alu_b, 1);
        check("lat_alu_op", alu_op, 5);
        check("lat_rsp_early", rsp_valid, 0);
        tick();
        check("lat_rsp_valid", rsp_valid, 1);
        check("lat_rsp_y", rsp_y, 0);
        check("lat_rsp_flags", rsp_flags, 4'b1010);
        check("lat_rsp_tag", rsp_tag, 2);
        check("lat_sticky", sticky_flags, 2'b10);
        tick();
        check("lat_rsp_gone", rsp_valid, 0);

        // sticky clear alone, then clear coinciding with a carry capture
        flags_clr = 1;
        tick();
        flags_clr = 0;
        check("clr_alone", sticky_flags, 2'b00);
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 0, 4'd3);
        tick();
        cmd_valid = 0;
        tick();
        flags_clr = 1;
        tick();
        flags_clr = 0;
        check("clr_vs_capture", sticky_flags, 2'b10);
        tick();

        // accumulate chain without bubbles
        for (int c = 0; c < 8; c++) begin
            if (c == 0)     send(32'd10, 32'd0, 4'd1, 0, 4'(c));
            else if (c < 5) send(32'hDEAD_BEEF, 32'd1, 4'd1, 1, 4'(c));
            else            cmd_valid = 0;
            if (c >= 3) begin
                check("chain_valid", rsp_valid, 1);
                check("chain_y", rsp_y, 32'(10 + c - 3));
            end
            tick();
        end
        check("chain_acc", acc_value, 14);

        // backpressure fills exactly DEPTH+2 entries
        rsp_ready = 0; nacc = 0;
        send(32'd0, 32'd100, 4'd2, 0, 4'd0);
        repeat (12) begin
            @(negedge clk);
            if (cmd_ready) nacc++;
            tick();
            cmd_tag = 4'(nacc); cmd_a = 32'(nacc);
        end
        check("bp_accepted", nacc, 6);
        check("bp_ready_low", cmd_ready, 0);
        check("bp_head_tag", rsp_tag, 0);
        check("bp_head_y", rsp_y, 100);

        // one pop while full: no accept in that cycle, accept on the next
        got.delete();
        rsp_ready = 1;
        @(negedge clk);
        check("full_pop_no_accept", cmd_ready, 0);
        got.push_back(rsp_tag);
        tick();
        rsp_ready = 0;
        @(negedge clk);
        check("full_next_accept", cmd_ready, 1);
        nacc++;
        tick();
        cmd_tag = 4'(nacc); cmd_a = 32'(nacc);
        rsp_ready = 1;
        for (int i = 0; i < 30 && got.size() < 8; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) nacc++;
            if (rsp_valid && rsp_ready) got.push_back(rsp_tag);
            tick();
            if (nacc >= 8) cmd_valid = 0;
            else begin cmd_tag = 4'(nacc); cmd_a = 32'(nacc); end
        end
        cmd_valid = 0;
        check("order_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) check("order_tag", got[i], i);

        // reset with work in flight
        rsp_ready = 0;
        send(32'hFFFF_FFFF, 32'd1, 4'd0, 0, 4'd10);
        tick();
        for (int i = 11; i < 15; i++) begin
            send(32'(i), 32'd1, 4'd0, 0, 4'(i));
            tick();
        end
        cmd_valid = 0;
        repeat (2) tick();
        check("mid_rsp_pending", rsp_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_acc", acc_value, 0);
        check("mid_sticky", sticky_flags, 0);
        rsp_ready = 1;
        send(32'd3, 32'd4, 4'd0, 0, 4'd9);
        tick();
        cmd_valid = 0;
        seen = 0; last_tag = '0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin seen++; last_tag = rsp_tag; end
            tick();
        end
        check("mid_single_count", seen, 1);
        check("mid_single_tag", last_tag, 9);

        // random traffic
        repeat (1500) begin
            rst       = ($urandom_range(0, 299) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_a     = pick();
            cmd_b     = pick();
            cmd_op    = 4'($urandom);
            cmd_acc   = 1'($urandom_range(0, 1));
            cmd_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            flags_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 0; cmd_valid = 0; rsp_ready = 1; flags_clr = 0;
        repeat (20) tick();
        check("drain_empty", q.size(), 0);
        check("drain_rsp_valid", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
